hazard_stall_controller: RTL and testbench

Pipeline sequencing block for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes control signals produced by the instruction decoder for the ID and EX stages, the EX branch result, and the data-cache miss handshake.
- Drives per-stage stall/flush signals.
- Contains a miss-wait FSM with timeout, plus saturating performance counters readable through CSR logic.

---
 rtl/hazard_stall_controller_pkg.sv | 10 +
 rtl/hazard_stall_controller_sat_counter.sv | 31 +++
 rtl/hazard_stall_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MISS = 2'd1,
        S_ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_stall_controller_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] out
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencing for the 5-stage core: load-use, control-flow flushes
// and the data-cache miss wait with timeout, plus performance counters.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wb_select,
    input  logic             ex_reg_write_en,
    input  logic             ex_br_taken,
    input  logic             id_jal,
    input  logic             mem_req,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic             miss_timeout,
    output logic [CNT_W-1:0] perf_miss_cycles,
    output logic [CNT_W-1:0] perf_loaduse,
    output logic [CNT_W-1:0] perf_flush
);

    localparam int TW = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          load_use;
    logic          miss_evt, loaduse_evt, flush_evt;

    assign load_use = ex_wb_select && ex_reg_write_en && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        flush_wb    = 1'b0;
        miss_evt    = 1'b0;
        loaduse_evt = 1'b0;
        flush_evt   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_req && dcache_miss) begin
                    // The entry cycle already freezes the pipe, so it is counted as a miss cycle.
                    state_d   = S_MISS;
                    tcnt_d    = '0;
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    flush_wb  = 1'b1;
                    miss_evt  = 1'b1;
                end else if (ex_br_taken) begin
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    flush_evt = 1'b1;
                end else if (load_use) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    flush_ex    = 1'b1;
                    loaduse_evt = 1'b1;
                end else if (id_jal) begin
                    flush_id  = 1'b1;
                    flush_evt = 1'b1;
                end
            end
            S_MISS: begin
                miss_evt = 1'b1;
                if (dcache_ready) begin
                    state_d = S_RUN;
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    flush_wb  = 1'b1;
                    tcnt_d    = tcnt_q + TW'(1);
                    if ((MISS_TIMEOUT != 0) && (tcnt_q == TW'(MISS_TIMEOUT - 1))) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                flush_wb  = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign miss_timeout = (state_q == S_ERR);

    hazard_stall_controller_sat_counter #(.W(CNT_W)) u_cnt_miss (
        .clk (clk),
        .rst (rst),
        .inc (miss_evt),
        .out (perf_miss_cycles)
    );

    hazard_stall_controller_sat_counter #(.W(CNT_W)) u_cnt_loaduse (
        .clk (clk),
        .rst (rst),
        .inc (loaduse_evt),
        .out (perf_loaduse)
    );

    hazard_stall_controller_sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .inc (flush_evt),
        .out (perf_flush)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MISS_TIMEOUT=8, CNT_W=4 build).
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_wb_select, ex_reg_write_en;
    logic       ex_br_taken, id_jal, mem_req, dcache_miss, dcache_ready;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, miss_timeout;
    logic [3:0] perf_miss_cycles, perf_loaduse, perf_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MISS_TIMEOUT(8), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_rd            (ex_rd),
        .ex_wb_select     (ex_wb_select),
        .ex_reg_write_en  (ex_reg_write_en),
        .ex_br_taken      (ex_br_taken),
        .id_jal           (id_jal),
        .mem_req          (mem_req),
        .dcache_miss      (dcache_miss),
        .dcache_ready     (dcache_ready),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .stall_ex         (stall_ex),
        .stall_mem        (stall_mem),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex),
        .flush_wb         (flush_wb),
        .miss_timeout     (miss_timeout),
        .perf_miss_cycles (perf_miss_cycles),
        .perf_loaduse     (perf_loaduse),
        .perf_flush       (perf_flush)
    );

    // ctl bit order: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
    logic [6:0] ctl;
    assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_wb_select = 0; ex_reg_write_en = 0;
        ex_br_taken = 0; id_jal = 0; mem_req = 0; dcache_miss = 0; dcache_ready = 0;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl), 32'h0);
        chk("reset_timeout", 32'(miss_timeout), 32'h0);
        chk("reset_cnt", {20'b0, perf_miss_cycles, perf_loaduse, perf_flush}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // load-use on rs1
        ex_wb_select = 1; ex_reg_write_en = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
        #1 chk("loaduse_rs1", 32'(ctl), 32'b1100010);
        tick();
        clear_inputs();
        #1 chk("loaduse_release", 32'(ctl), 32'h0);
        chk("loaduse_cnt1", 32'(perf_loaduse), 32'd1);
        // rd = x0 never hazards
        ex_wb_select = 1; ex_reg_write_en = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
        #1 chk("loaduse_x0", 32'(ctl), 32'h0);
        // matching index but operand unused
        ex_rd = 9; id_rs1 = 9; id_use_rs1 = 0;
        #1 chk("loaduse_unused", 32'(ctl), 32'h0);
        // load-use on rs2
        id_use_rs2 = 1; id_rs2 = 9;
        #1 chk("loaduse_rs2", 32'(ctl), 32'b1100010);
        tick();
        clear_inputs();
        #1 chk("loaduse_cnt2", 32'(perf_loaduse), 32'd2);

        // branch beats a simultaneous jal and load-use
        ex_br_taken = 1; id_jal = 1;
        ex_wb_select = 1; ex_reg_write_en = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3;
        #1 chk("branch_over_jal", 32'(ctl), 32'b0000110);
        tick();
        clear_inputs();
        #1 chk("branch_flush_cnt", 32'(perf_flush), 32'd1);
        chk("branch_no_loaduse_cnt", 32'(perf_loaduse), 32'd2);
        id_jal = 1;
        #1 chk("jal_only", 32'(ctl), 32'b0000100);
        tick();
        clear_inputs();
        #1 chk("jal_flush_cnt", 32'(perf_flush), 32'd2);

        // ready while running is ignored
        dcache_ready = 1;
        #1 chk("ready_in_run", 32'(ctl), 32'h0);
        tick();
        dcache_ready = 0;
        #1 chk("ready_in_run_next", 32'(ctl), 32'h0);

        // miss: entry + 4 stalled MISS cycles, ready on the 5th MISS cycle
        mem_req = 1; dcache_miss = 1;
        #1 chk("miss_entry", 32'(ctl), 32'b1111001);
        tick();
        dcache_miss = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("miss_wait", 32'(ctl), 32'b1111001);
            tick();
        end
        dcache_ready = 1;
        #1 chk("miss_ready", 32'(ctl), 32'h0);
        tick();
        clear_inputs();
        #1 chk("miss_back_run", 32'(ctl), 32'h0);
        chk("miss_cycles6", 32'(perf_miss_cycles), 32'd6);

        // branch during a miss is deferred until release
        mem_req = 1; dcache_miss = 1; ex_br_taken = 1;
        #1 chk("missbr_entry", 32'(ctl), 32'b1111001);
        tick();
        dcache_miss = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("missbr_wait", 32'(ctl), 32'b1111001);
            tick();
        end
        dcache_ready = 1;
        #1 chk("missbr_ready", 32'(ctl), 32'h0);
        tick();
        dcache_ready = 0; mem_req = 0;
        #1 chk("missbr_release_flush", 32'(ctl), 32'b0000110);
        tick();
        clear_inputs();
        #1 chk("missbr_flush_cnt", 32'(perf_flush), 32'd3);
        chk("missbr_miss_cnt", 32'(perf_miss_cycles), 32'd10);

        // saturation of a 4-bit counter
        pulse_reset();
        chk("sat_after_reset", 32'(perf_flush), 32'd0);
        id_jal = 1;
        for (int i = 0; i < 20; i++) tick();
        #1 chk("sat_flush15", 32'(perf_flush), 32'd15);
        tick();
        #1 chk("sat_flush_hold", 32'(perf_flush), 32'd15);
        clear_inputs();

        // timeout: entry, then 8 MISS cycles without ready -> ERR
        pulse_reset();
        tick();
        mem_req = 1; dcache_miss = 1;
        tick();
        dcache_miss = 0;
        for (int i = 0; i < 8; i++) begin
            #1 chk("to_not_yet", 32'(miss_timeout), 32'd0);
            tick();
        end
        #1 chk("to_flag", 32'(miss_timeout), 32'd1);
        chk("to_err_ctl", 32'(ctl), 32'b1111001);
        chk("to_miss_cnt", 32'(perf_miss_cycles), 32'd9);
        dcache_ready = 1;
        tick(); tick(); tick();
        #1 chk("to_sticky", 32'(miss_timeout), 32'd1);
        chk("to_err_hold", 32'(ctl), 32'b1111001);
        chk("to_cnt_frozen", 32'(perf_miss_cycles), 32'd9);

        // asynchronous reset mid-cycle in ERR
        clear_inputs();
        #1 rst = 1'b1;
        #1 chk("rst_err_timeout", 32'(miss_timeout), 32'd0);
        chk("rst_err_cnt", 32'(perf_miss_cycles), 32'd0);
        chk("rst_err_ctl", 32'(ctl), 32'h0);
        rst = 1'b0;
        tick();
        #1 chk("rst_err_run", 32'(ctl), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
